slt_seq_compare: RTL and testbench

Parametrised, multi-cycle set-on-compare unit for the MIPS datapath. It generalises the 32-bit set-less-than path to any operand width and adds signed/unsigned less-than, equal and not-equal modes. Operands are compared MSB-first in CHUNK-bit slices, one slice per clock, with optional early termination. Valid/ready handshakes on both sides let it sit behind the ALU operand muxes as a shared, back-pressurable compare resource.

---
 rtl/slt_seq_compare.sv | 135 +++++++++++++
 tb/tb_slt_seq_compare.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/slt_seq_compare.sv
// Multi-cycle set-on-compare unit: SLT/SLTU/SEQ/SNE over WIDTH-bit operands,
// compared MSB-first one CHUNK-bit slice per clock, with valid/ready on both sides.
module slt_seq_compare #(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] KTOP = KW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_SLT  = 2'b00,
        OP_SLTU = 2'b01,
        OP_SEQ  = 2'b10,
        OP_SNE  = 2'b11
    } op_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    op_t              op_q, op_d;
    logic [KW-1:0]    k_q, k_d;
    logic             decided_q, decided_d;
    logic             lt_q, lt_d;

    logic [CHUNK-1:0] sa, sb;
    logic             slice_ne;
    logic             res_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_SLT;
            k_q       <= KTOP;
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            k_q       <= k_d;
            decided_q <= decided_d;
            lt_q      <= lt_d;
        end
    end

    // Flipping both sign bits of the top slice turns the signed compare into an unsigned one.
    always_comb begin
        sa = a_q[int'(k_q)*CHUNK +: CHUNK];
        sb = b_q[int'(k_q)*CHUNK +: CHUNK];
        if (op_q == OP_SLT && k_q == KTOP) begin
            sa[CHUNK-1] = ~sa[CHUNK-1];
            sb[CHUNK-1] = ~sb[CHUNK-1];
        end
        slice_ne = (sa != sb);
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        k_d       = k_q;
        decided_d = decided_q;
        lt_d      = lt_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d       = a;
                    b_d       = b;
                    op_d      = op_t'(op);
                    k_d       = KTOP;
                    decided_d = 1'b0;
                    lt_d      = 1'b0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (!decided_q && slice_ne) begin
                    decided_d = 1'b1;
                    lt_d      = (sa < sb);
                end
                if (k_q == '0 || (EARLY_EXIT != 0 && !decided_q && slice_ne)) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q - KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        unique case (op_q)
            OP_SLT, OP_SLTU: res_bit = decided_q & lt_q;
            OP_SEQ:          res_bit = ~decided_q;
            default:         res_bit = decided_q;
        endcase
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        result    = '0;
        result[0] = out_valid & res_bit;
    end

endmodule

// File: tb/tb_slt_seq_compare.sv
// Directed and random checks of slt_seq_compare with EARLY_EXIT=1 and EARLY_EXIT=0
// instances driven from the same inputs.
module tb_slt_seq_compare;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  op = 2'b00;

    logic        in_ready0, out_valid0, busy0;
    logic        in_ready1, out_valid1, busy1;
    logic [31:0] result0, result1;

    int total = 0;
    int bad   = 0;

    time prev_acc;
    int  prev_m;
    bit  have_prev = 1'b0;

    always #5 clk = ~clk;

    slt_seq_compare #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .op(op), .out_valid(out_valid0), .out_ready(out_ready),
        .result(result0), .busy(busy0)
    );

    slt_seq_compare #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .op(op), .out_valid(out_valid1), .out_ready(out_ready),
        .result(result1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            2'b00:   return $signed(x) < $signed(y);
            2'b01:   return x < y;
            2'b10:   return x == y;
            default: return x != y;
        endcase
    endfunction

    function automatic int ref_m(input logic [31:0] x, input logic [31:0] y);
        for (int i = 3; i >= 0; i--)
            if (x[i*8 +: 8] != y[i*8 +: 8]) return 4 - i;
        return 4;
    endfunction

    // One transaction on both instances; stall=1 inserts random out_ready gaps.
    task automatic run_txn(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                           input logic exp_r, input int exp_m0, input bit stall);
        int   n = 0;
        bit   seen0 = 0, seen1 = 0, done0 = 0, done1 = 0;
        logic pv0, pv1, ordy;
        logic [31:0] r0 = '0, r1 = '0;

        chk("ready0_before", {31'd0, in_ready0}, 32'd1);
        chk("ready1_before", {31'd0, in_ready1}, 32'd1);
        op = o; a = xa; b = xb; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (have_prev) chk("issue_interval_ok", {31'd0, (($time - prev_acc) / 10) >= prev_m + 2}, 32'd1);
        prev_acc = $time; prev_m = exp_m0; have_prev = 1'b1;
        a = $urandom; b = $urandom; op = 2'($urandom);
        out_ready = !stall || ($urandom_range(0, 2) != 0);

        while (!(done0 && done1) && n < 60) begin
            pv0 = out_valid0; pv1 = out_valid1; ordy = out_ready;
            @(posedge clk);
            #1;
            n++;
            if (!done0 && pv0 && ordy) begin
                done0 = 1;
                chk("ready0_after_hs", {31'd0, in_ready0}, 32'd1);
            end
            if (!done1 && pv1 && ordy) begin
                done1 = 1;
                chk("ready1_after_hs", {31'd0, in_ready1}, 32'd1);
            end
            if (!done0) begin
                chk("ready0_busy", {31'd0, in_ready0}, 32'd0);
                if (out_valid0 && !seen0) begin
                    seen0 = 1; r0 = result0;
                    chk("result0", result0, {31'd0, exp_r});
                    chk("latency0", n, exp_m0);
                end else if (seen0) begin
                    chk("hold0", result0, r0);
                    chk("hold_valid0", {31'd0, out_valid0}, 32'd1);
                end
            end
            if (!done1) begin
                chk("ready1_busy", {31'd0, in_ready1}, 32'd0);
                if (out_valid1 && !seen1) begin
                    seen1 = 1; r1 = result1;
                    chk("result1", result1, {31'd0, exp_r});
                    chk("latency1", n, 4);
                end else if (seen1) begin
                    chk("hold1", result1, r1);
                end
            end
            out_ready = !stall || ($urandom_range(0, 2) != 0);
        end
        if (!(done0 && done1)) chk("txn_timeout", 32'd0, 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready0}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_result", result0, 32'd0);
        reset = 1'b0;

        run_txn(2'b00, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1, 0);
        run_txn(2'b01, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1, 0);
        run_txn(2'b00, 32'h80000000, 32'h00000001, 1'b1, 1, 0);
        run_txn(2'b00, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1, 0);
        run_txn(2'b01, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1, 0);
        run_txn(2'b10, 32'h12345678, 32'h12345678, 1'b1, 4, 0);
        run_txn(2'b11, 32'h12345678, 32'h12345678, 1'b0, 4, 0);
        run_txn(2'b00, 32'h12345677, 32'h12345678, 1'b1, 4, 0);
        run_txn(2'b01, 32'h00010000, 32'h00020000, 1'b1, 2, 0);
        run_txn(2'b10, 32'h12000000, 32'h13000000, 1'b0, 1, 0);
        run_txn(2'b11, 32'hAB00CD00, 32'hAB00CE00, 1'b1, 3, 0);

        // Backpressure: both instances finish after 4 slices here.
        op = 2'b01; a = 32'd1; b = 32'd2; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_valid", {31'd0, out_valid0}, 32'd1);
        chk("bp_result", result0, 32'd1);
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom; op = 2'($urandom); in_valid = ~in_valid;
            @(posedge clk);
            #1;
            chk("bp_hold_result", result0, 32'd1);
            chk("bp_hold_valid", {31'd0, out_valid0}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready0}, 32'd0);
            chk("bp_hold_result1", result1, 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_ready", {31'd0, in_ready0}, 32'd1);
        chk("bp_release_valid", {31'd0, out_valid0}, 32'd0);
        chk("bp_release_ready1", {31'd0, in_ready1}, 32'd1);
        out_ready = 1'b0;

        // Reset on the second RUN cycle.
        op = 2'b10; a = 32'h55555555; b = 32'h55555555; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("midrun_busy", {31'd0, busy0}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mr_out_valid", {31'd0, out_valid0}, 32'd0);
        chk("mr_result", result0, 32'd0);
        chk("mr_in_ready", {31'd0, in_ready0}, 32'd1);
        chk("mr_busy", {31'd0, busy0}, 32'd0);
        chk("mr_busy1", {31'd0, busy1}, 32'd0);
        have_prev = 1'b0;
        run_txn(2'b01, 32'd3, 32'd5, 1'b1, 4, 0);

        // Reset together with in_valid: nothing accepted.
        reset = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_vs_valid_busy", {31'd0, busy0}, 32'd0);
        chk("rst_vs_valid_ready", {31'd0, in_ready0}, 32'd1);
        have_prev = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = {ra[31:8], rb[7:0]};
                2: rb = {ra[31:16], rb[15:0]};
                default: ;
            endcase
            run_txn(ro, ra, rb, ref_res(ro, ra, rb), ref_m(ra, rb), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
